pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the five-stage core, replacing the hand-written per-stage latches (EX/MEM first, then ID/EX and MEM/WB).
- Carries a generic payload bus plus a valid bit from the upstream stage to the downstream stage.
- Honours the two stall bits for its position, a flush request and bubble insertion.
- Carries multi-cycle scratch state (accumulator, step counter) across self-stalls.
- Adds a saturating stall-duration counter for debug and performance monitoring.

---
 rtl/pipe_stage_reg_pkg.sv | 36 +++
 rtl/pipe_stage_reg_sat_counter.sv | 26 ++
 rtl/pipe_stage_reg.sv | 105 ++++++++++
 tb/tb_pipe_stage_reg.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions (header.v equivalents) and the per-edge action
// decode used by the inter-stage pipeline register.
package pipe_stage_reg_pkg;

  localparam logic        RstEnable    = 1'b1;
  localparam logic        Stop         = 1'b1;
  localparam logic        NoStop       = 1'b0;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [7:0]  EXE_NOP_OP   = 8'b0000_0000;

  typedef enum logic [1:0] {
    ACT_FLUSH   = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_ADVANCE = 2'd2,
    ACT_HOLD    = 2'd3
  } stage_act_t;

  // stall_self=0 with stall_next=1 is not a legal controller output; it falls
  // through to advance so a bad stall vector never freezes the pipe.
  function automatic stage_act_t decode_act(input logic flush,
                                            input logic stall_self,
                                            input logic stall_next);
    stage_act_t act;
    if (flush)
      act = ACT_FLUSH;
    else if (stall_self == Stop && stall_next == NoStop)
      act = ACT_BUBBLE;
    else if (stall_self == NoStop)
      act = ACT_ADVANCE;
    else
      act = ACT_HOLD;
    return act;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; used to measure stall length.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    if (v == {WIDTH{1'b1}})
      return v;
    else
      return v + WIDTH'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc)
      cnt <= sat_inc(cnt);
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: payload + valid with stall,
// flush and bubble handling, multi-cycle scratch carry and a stall counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                   PAYLOAD_W  = 128,
  parameter logic [PAYLOAD_W-1:0] NOP_VALUE  = '0,
  parameter int                   SCRATCH_W  = 64,
  parameter int                   STEP_W     = 2,
  parameter int                   STALLCNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_self,
  input  logic                  stall_next,
  input  logic                  flush,
  input  logic                  valid_i,
  input  logic [PAYLOAD_W-1:0]  payload_i,
  input  logic [SCRATCH_W-1:0]  scratch_i,
  input  logic [STEP_W-1:0]     step_i,
  output logic                  valid_o,
  output logic [PAYLOAD_W-1:0]  payload_o,
  output logic [SCRATCH_W-1:0]  scratch_o,
  output logic [STEP_W-1:0]     step_o,
  output logic [STALLCNT_W-1:0] stall_cycles_o,
  output logic                  bubble_o
);

  stage_act_t           act_p0;
  logic                 stall_inc_p0;
  logic                 stall_clr_p0;
  logic                 vld_p1;
  logic [PAYLOAD_W-1:0] payload_p1;
  logic [SCRATCH_W-1:0] scratch_p1;
  logic [STEP_W-1:0]    step_p1;
  logic                 bubble_p1;

  always_comb begin
    act_p0       = decode_act(flush, stall_self, stall_next);
    stall_inc_p0 = (act_p0 == ACT_BUBBLE) || (act_p0 == ACT_HOLD);
    stall_clr_p0 = (act_p0 == ACT_FLUSH) || (act_p0 == ACT_ADVANCE);
  end

  // p0 -> p1: the single register stage between upstream and downstream
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      payload_p1 <= NOP_VALUE;
      vld_p1     <= 1'b0;
      scratch_p1 <= '0;
      step_p1    <= '0;
      bubble_p1  <= 1'b0;
    end else begin
      unique case (act_p0)
        ACT_FLUSH: begin
          payload_p1 <= NOP_VALUE;
          vld_p1     <= 1'b0;
          scratch_p1 <= '0;
          step_p1    <= '0;
          bubble_p1  <= 1'b0;
        end
        ACT_BUBBLE: begin
          payload_p1 <= NOP_VALUE;
          vld_p1     <= 1'b0;
          scratch_p1 <= scratch_i;
          step_p1    <= step_i;
          bubble_p1  <= 1'b1;
        end
        ACT_ADVANCE: begin
          payload_p1 <= payload_i;
          vld_p1     <= valid_i;
          scratch_p1 <= '0;
          step_p1    <= '0;
          bubble_p1  <= 1'b0;
        end
        default: begin
          // hold: payload/valid keep their value, scratch still tracks the
          // execute logic so multi-cycle ops see their own previous step
          scratch_p1 <= scratch_i;
          step_p1    <= step_i;
          bubble_p1  <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH(STALLCNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc_p0),
    .clr (stall_clr_p0),
    .cnt (stall_cycles_o)
  );

  assign payload_o = payload_p1;
  assign valid_o   = vld_p1;
  assign scratch_o = scratch_p1;
  assign step_o    = step_p1;
  assign bubble_o  = bubble_p1;

  a_legal_stall: assert property (@(posedge clk) disable iff (rst)
                                  !(stall_next && !stall_self));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a default instance plus a narrow-counter
// instance with a non-zero NOP_VALUE, both driven by the same stimulus.
module tb_pipe_stage_reg;

  localparam int PW = 128;
  localparam int SW = 64;
  localparam int TW = 2;
  localparam logic [PW-1:0] NOP2 = 128'h1F;

  logic          clk = 1'b0;
  logic          rst, stall_self, stall_next, flush, valid_i;
  logic [PW-1:0] payload_i;
  logic [SW-1:0] scratch_i;
  logic [TW-1:0] step_i;

  logic          valid_o, bubble_o, valid2, bubble2;
  logic [PW-1:0] payload_o, payload2;
  logic [SW-1:0] scratch_o, scratch2;
  logic [TW-1:0] step_o, step2;
  logic [7:0]    stall_cycles_o;
  logic [1:0]    stall2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .stall_self(stall_self), .stall_next(stall_next),
    .flush(flush), .valid_i(valid_i), .payload_i(payload_i),
    .scratch_i(scratch_i), .step_i(step_i), .valid_o(valid_o),
    .payload_o(payload_o), .scratch_o(scratch_o), .step_o(step_o),
    .stall_cycles_o(stall_cycles_o), .bubble_o(bubble_o)
  );

  pipe_stage_reg #(.NOP_VALUE(NOP2), .STALLCNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .stall_self(stall_self), .stall_next(stall_next),
    .flush(flush), .valid_i(valid_i), .payload_i(payload_i),
    .scratch_i(scratch_i), .step_i(step_i), .valid_o(valid2),
    .payload_o(payload2), .scratch_o(scratch2), .step_o(step2),
    .stall_cycles_o(stall2), .bubble_o(bubble2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_self = 1'b0; stall_next = 1'b0; flush = 1'b0;
    valid_i = 1'b1; payload_i = '1; scratch_i = '1; step_i = '1;
    for (int c = 0; c < 2; c++) begin
      tick();
      tests++; if (payload_o !== '0) begin fails++; $display("FAIL reset_payload c%0d: got %h want 0", c, payload_o); end
      tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid c%0d: got %b want 0", c, valid_o); end
      tests++; if (scratch_o !== '0 || step_o !== '0) begin fails++; $display("FAIL reset_scratch c%0d: got %h/%0d want 0/0", c, scratch_o, step_o); end
      tests++; if (stall_cycles_o !== 8'd0 || bubble_o !== 1'b0) begin fails++; $display("FAIL reset_cnt c%0d: got %0d/%b want 0/0", c, stall_cycles_o, bubble_o); end
      tests++; if (payload2 !== NOP2 || stall2 !== 2'd0) begin fails++; $display("FAIL reset_nop2 c%0d: got %h/%0d want %h/0", c, payload2, stall2, NOP2); end
    end
  endtask

  task automatic test_advance();
    rst = 1'b0; valid_i = 1'b1; payload_i = 128'hDEADBEEF;
    scratch_i = 64'h1234; step_i = 2'd3;
    tick();
    tests++; if (payload_o !== 128'hDEADBEEF) begin fails++; $display("FAIL adv_payload: got %h want deadbeef", payload_o); end
    tests++; if (valid_o !== 1'b1) begin fails++; $display("FAIL adv_valid: got %b want 1", valid_o); end
    tests++; if (scratch_o !== '0 || step_o !== '0) begin fails++; $display("FAIL adv_scratch: got %h/%0d want 0/0", scratch_o, step_o); end
    tests++; if (bubble_o !== 1'b0 || stall_cycles_o !== 8'd0) begin fails++; $display("FAIL adv_ctl: got %b/%0d want 0/0", bubble_o, stall_cycles_o); end
  endtask

  task automatic test_bubble();
    stall_self = 1'b1; stall_next = 1'b0; payload_i = 128'h77;
    scratch_i = 64'h0000_0001_0000_0002; step_i = 2'd1;
    tick();
    tests++; if (payload_o !== '0 || valid_o !== 1'b0) begin fails++; $display("FAIL bub_payload: got %h/%b want 0/0", payload_o, valid_o); end
    tests++; if (bubble_o !== 1'b1) begin fails++; $display("FAIL bub_flag: got %b want 1", bubble_o); end
    tests++; if (scratch_o !== 64'h0000_0001_0000_0002 || step_o !== 2'd1) begin fails++; $display("FAIL bub_carry: got %h/%0d want 0000000100000002/1", scratch_o, step_o); end
    tests++; if (stall_cycles_o !== 8'd1 || payload2 !== NOP2) begin fails++; $display("FAIL bub_cnt: got %0d/%h want 1/%h", stall_cycles_o, payload2, NOP2); end
    // hold right after the bubble must keep the NOP payload
    stall_next = 1'b1; scratch_i = 64'h0000_0003_0000_0004; step_i = 2'd2;
    tick();
    tests++; if (payload_o !== '0 || valid_o !== 1'b0) begin fails++; $display("FAIL bub_hold_payload: got %h/%b want 0/0", payload_o, valid_o); end
    tests++; if (bubble_o !== 1'b0 || stall_cycles_o !== 8'd2) begin fails++; $display("FAIL bub_hold_ctl: got %b/%0d want 0/2", bubble_o, stall_cycles_o); end
    tests++; if (scratch_o !== 64'h0000_0003_0000_0004 || step_o !== 2'd2) begin fails++; $display("FAIL bub_hold_carry: got %h/%0d want 0000000300000004/2", scratch_o, step_o); end
  endtask

  task automatic test_hold();
    stall_self = 1'b0; stall_next = 1'b0; valid_i = 1'b1; payload_i = 128'hA5;
    tick();
    tests++; if (payload_o !== 128'hA5 || stall_cycles_o !== 8'd0) begin fails++; $display("FAIL hold_load: got %h/%0d want a5/0", payload_o, stall_cycles_o); end
    stall_self = 1'b1; stall_next = 1'b1; payload_i = 128'h5A; valid_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      scratch_i = 64'(i * 16 + 1); step_i = 2'(i);
      tick();
      tests++; if (payload_o !== 128'hA5 || valid_o !== 1'b1) begin fails++; $display("FAIL hold_payload c%0d: got %h/%b want a5/1", i, payload_o, valid_o); end
      tests++; if (stall_cycles_o !== 8'(i)) begin fails++; $display("FAIL hold_cnt c%0d: got %0d want %0d", i, stall_cycles_o, i); end
      tests++; if (scratch_o !== 64'(i * 16 + 1) || step_o !== 2'(i)) begin fails++; $display("FAIL hold_carry c%0d: got %h/%0d want %h/%0d", i, scratch_o, step_o, i * 16 + 1, i); end
    end
    stall_self = 1'b0; stall_next = 1'b0; valid_i = 1'b1;
    tick();
    tests++; if (payload_o !== 128'h5A || stall_cycles_o !== 8'd0) begin fails++; $display("FAIL hold_release: got %h/%0d want 5a/0", payload_o, stall_cycles_o); end
    tests++; if (scratch_o !== '0 || step_o !== '0) begin fails++; $display("FAIL hold_release_scratch: got %h/%0d want 0/0", scratch_o, step_o); end
  endtask

  task automatic test_flush();
    stall_self = 1'b1; stall_next = 1'b1; scratch_i = 64'hFF; step_i = 2'd1;
    tick();
    flush = 1'b1; step_i = 2'd2; scratch_i = 64'hABCD;
    tick();
    tests++; if (payload_o !== '0 || valid_o !== 1'b0) begin fails++; $display("FAIL flush_payload: got %h/%b want 0/0", payload_o, valid_o); end
    tests++; if (step_o !== '0 || scratch_o !== '0) begin fails++; $display("FAIL flush_scratch: got %h/%0d want 0/0", scratch_o, step_o); end
    tests++; if (stall_cycles_o !== 8'd0 || payload2 !== NOP2) begin fails++; $display("FAIL flush_cnt: got %0d/%h want 0/%h", stall_cycles_o, payload2, NOP2); end
    stall_next = 1'b0;
    tick();
    tests++; if (bubble_o !== 1'b0 || stall_cycles_o !== 8'd0) begin fails++; $display("FAIL flush_over_bubble: got %b/%0d want 0/0", bubble_o, stall_cycles_o); end
    flush = 1'b0;
  endtask

  task automatic test_saturation();
    logic [1:0] exp2 [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    stall_self = 1'b1; stall_next = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++; if (stall2 !== exp2[i]) begin fails++; $display("FAIL sat_cnt c%0d: got %0d want %0d", i, stall2, exp2[i]); end
    end
    tests++; if (stall_cycles_o !== 8'd6) begin fails++; $display("FAIL sat_wide: got %0d want 6", stall_cycles_o); end
    rst = 1'b1;
    tick();
    tests++; if (stall2 !== 2'd0 || stall_cycles_o !== 8'd0) begin fails++; $display("FAIL sat_rst: got %0d/%0d want 0/0", stall2, stall_cycles_o); end
    tests++; if (payload2 !== NOP2 || scratch2 !== '0 || step2 !== '0 || valid2 !== 1'b0 || bubble2 !== 1'b0) begin fails++; $display("FAIL sat_rst_state: got %h/%h/%0d/%b/%b", payload2, scratch2, step2, valid2, bubble2); end
    rst = 1'b0; stall_self = 1'b0; stall_next = 1'b0;
  endtask

  initial begin
    test_reset();
    test_advance();
    test_bubble();
    test_hold();
    test_flush();
    test_saturation();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
